// File: rtl/m_unit_pcpi_issue_pkg.sv
// Shared definitions for the PCPI issue stage: opcodes, func3 encodings,
// the modulus Q and the issue FSM state type.
package m_definitions;

  localparam logic [6:0]  OPCODE        = 7'h33;
  localparam logic [6:0]  OPCODE_CUSTOM = 7'h0b;
  localparam logic [6:0]  FUNCT7_M      = 7'b0000001;
  localparam logic [31:0] Q             = 32'd3329;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } func3_t;

  typedef enum logic [2:0] {
    ADDMOD = 3'd0,
    SUBMOD = 3'd1,
    MULQ   = 3'd2
  } func3_custom_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    HOLD  = 3'd4,
    FLUSH = 3'd5
  } issue_state_t;

  function automatic logic is_custom_m(input logic [2:0] f3);
    return (f3 == ADDMOD) || (f3 == SUBMOD) || (f3 == MULQ);
  endfunction

endpackage

// File: rtl/m_unit_pcpi_issue_decode.sv
// Combinational claim decode: RV32M on the standard opcode, or one of the
// three modular ops on the custom opcode.
module m_issue_decode
  import m_definitions::*;
(
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  input  logic [6:0] opcode,
  output logic       hit
);

  logic is_m_std;
  logic is_m_custom;

  always_comb begin
    is_m_std    = (opcode == OPCODE);
    is_m_custom = (opcode == OPCODE_CUSTOM) && is_custom_m(funct3);
    hit         = (funct7 == FUNCT7_M) && (is_m_std || is_m_custom);
  end

endmodule

// File: rtl/m_unit_pcpi_issue.sv
// PCPI issue/writeback stage: claims M-type instructions, launches them into
// riscv_m_unit, and returns a registered result with a one-cycle ready pulse.
module m_unit_pcpi_issue
  import m_definitions::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             pcpi_valid,
  input  logic [31:0]      pcpi_insn,
  input  logic [31:0]      pcpi_rs1,
  input  logic [31:0]      pcpi_rs2,
  output logic             pcpi_wr,
  output logic [31:0]      pcpi_rd,
  output logic             pcpi_wait,
  output logic             pcpi_ready,
  output logic             mu_valid,
  output logic [31:0]      mu_instruction,
  output logic [31:0]      mu_rs1,
  output logic [31:0]      mu_rs2,
  input  logic             mu_wr,
  input  logic [31:0]      mu_rd,
  input  logic             mu_busy,
  input  logic             mu_ready,
  output logic             timeout_err,
  output logic [CNT_W-1:0] op_count
);

  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  issue_state_t     state_q, state_d;
  logic [31:0]      insn_q, insn_d;
  logic [31:0]      rs1_q, rs1_d;
  logic [31:0]      rs2_q, rs2_d;
  logic [31:0]      rd_q, rd_d;
  logic             wr_q, wr_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             launched_q, launched_d;
  logic             timed_out_q, timed_out_d;
  logic             timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic             hit;

  m_issue_decode u_decode (
    .funct7 (pcpi_insn[31:25]),
    .funct3 (pcpi_insn[14:12]),
    .opcode (pcpi_insn[6:0]),
    .hit    (hit)
  );

  always_comb begin
    state_d       = state_q;
    insn_d        = insn_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    rd_d          = rd_q;
    wr_d          = wr_q;
    wd_d          = wd_q;
    launched_d    = launched_q;
    timed_out_d   = timed_out_q;
    timeout_err_d = timeout_err_q;
    op_count_d    = op_count_q;

    case (state_q)
      IDLE: begin
        if (pcpi_valid && hit) begin
          insn_d      = pcpi_insn;
          rs1_d       = pcpi_rs1;
          rs2_d       = pcpi_rs2;
          launched_d  = 1'b0;
          timed_out_d = 1'b0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (!pcpi_valid) begin
          launched_d = 1'b0;
          wd_d       = '0;
          state_d    = FLUSH;
        end else if (!mu_busy) begin
          launched_d = 1'b1;
          wd_d       = '0;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        // A result arriving together with the core's withdrawal is simply dropped.
        if (mu_ready) begin
          if (pcpi_valid) begin
            rd_d    = mu_rd;
            wr_d    = mu_wr;
            state_d = RESP;
          end else begin
            state_d = IDLE;
          end
        end else if (!pcpi_valid) begin
          wd_d    = '0;
          state_d = FLUSH;
        end else if (wd_q == WD_LAST) begin
          rd_d          = '0;
          wr_d          = 1'b0;
          timed_out_d   = 1'b1;
          timeout_err_d = 1'b1;
          state_d       = RESP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      RESP: begin
        if (!timed_out_q) begin
          op_count_d = op_count_q + 1'b1;
        end
        state_d = HOLD;
      end
      HOLD: begin
        state_d = IDLE;
      end
      FLUSH: begin
        // The watchdog also bounds the drain so a hung m-unit cannot wedge us here.
        if (!launched_q || mu_ready || (wd_q == WD_LAST)) begin
          state_d = IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      insn_q        <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_q          <= '0;
      wr_q          <= 1'b0;
      wd_q          <= '0;
      launched_q    <= 1'b0;
      timed_out_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      op_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      insn_q        <= insn_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      rd_q          <= rd_d;
      wr_q          <= wr_d;
      wd_q          <= wd_d;
      launched_q    <= launched_d;
      timed_out_q   <= timed_out_d;
      timeout_err_q <= timeout_err_d;
      op_count_q    <= op_count_d;
    end
  end

  // Launch depends on the live busy flag so the pulse lands in the first free cycle.
  assign mu_valid       = (state_q == ISSUE) && pcpi_valid && !mu_busy;
  assign pcpi_wait      = (state_q == ISSUE) || (state_q == WAIT);
  assign pcpi_ready     = (state_q == RESP);
  assign pcpi_rd        = rd_q;
  assign pcpi_wr        = wr_q;
  assign mu_instruction = insn_q;
  assign mu_rs1         = rs1_q;
  assign mu_rs2         = rs2_q;
  assign timeout_err    = timeout_err_q;
  assign op_count       = op_count_q;

endmodule

// File: tb/tb_m_unit_pcpi_issue.sv
// Directed bench for m_unit_pcpi_issue with a behavioural m-unit stub whose
// latency, busy flag and hang behaviour are controlled from the stimulus.
module tb_m_unit_pcpi_issue;
  import m_definitions::*;

  localparam int TO = 64;

  logic        clk;
  logic        resetn;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;
  logic        mu_valid;
  logic [31:0] mu_instruction;
  logic [31:0] mu_rs1;
  logic [31:0] mu_rs2;
  logic        mu_wr    = 1'b0;
  logic [31:0] mu_rd    = 32'h0;
  logic        mu_busy  = 1'b0;
  logic        mu_ready = 1'b0;
  logic        timeout_err;
  logic [31:0] op_count;

  int checks = 0;
  int errors = 0;

  int          stub_lat      = 1;
  bit          stub_hang     = 1'b0;
  int          stub_launches = 0;
  bit          stub_pending  = 1'b0;
  int          stub_cnt      = 0;
  logic [31:0] stub_res      = 32'h0;

  m_unit_pcpi_issue #(.TIMEOUT_CYCLES(TO), .CNT_W(32)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .pcpi_valid     (pcpi_valid),
    .pcpi_insn      (pcpi_insn),
    .pcpi_rs1       (pcpi_rs1),
    .pcpi_rs2       (pcpi_rs2),
    .pcpi_wr        (pcpi_wr),
    .pcpi_rd        (pcpi_rd),
    .pcpi_wait      (pcpi_wait),
    .pcpi_ready     (pcpi_ready),
    .mu_valid       (mu_valid),
    .mu_instruction (mu_instruction),
    .mu_rs1         (mu_rs1),
    .mu_rs2         (mu_rs2),
    .mu_wr          (mu_wr),
    .mu_rd          (mu_rd),
    .mu_busy        (mu_busy),
    .mu_ready       (mu_ready),
    .timeout_err    (timeout_err),
    .op_count       (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] opc);
    return {f7, 5'd12, 5'd11, f3, 5'd10, opc};
  endfunction

  // Behavioural reference for what riscv_m_unit would return.
  function automatic logic [31:0] mu_model(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
    logic [2:0]  f3;
    logic [63:0] p;
    f3 = insn[14:12];
    if (insn[6:0] == OPCODE_CUSTOM) begin
      case (f3)
        ADDMOD:  p = ({32'h0, a % Q} + {32'h0, b % Q}) % {32'h0, Q};
        SUBMOD:  p = ({32'h0, a % Q} + {32'h0, Q} - {32'h0, b % Q}) % {32'h0, Q};
        default: p = ({32'h0, a} * {32'h0, b}) % {32'h0, Q};
      endcase
      return p[31:0];
    end
    case (f3)
      MUL:    begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
      MULH:   begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
      MULHSU: begin p = $signed({{32{a[31]}}, a}) * $signed({32'h0, b}); return p[63:32]; end
      MULHU:  begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      DIV: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return $signed(a) / $signed(b);
      end
      DIVU:   return (b == 0) ? 32'hFFFFFFFF : a / b;
      REM: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // M-unit stub: acts just after each falling edge, so its outputs are stable at the next rising edge.
  always @(negedge clk) begin
    #1;
    if (!resetn) begin
      stub_pending = 1'b0;
      mu_ready     = 1'b0;
    end else begin
      mu_ready = 1'b0;
      if (stub_pending) begin
        if (stub_cnt <= 1) begin
          mu_ready     = 1'b1;
          mu_rd        = stub_res;
          mu_wr        = 1'b1;
          stub_pending = 1'b0;
        end else begin
          stub_cnt--;
        end
      end
      if (mu_valid) begin
        stub_launches++;
        stub_res = mu_model(mu_instruction, mu_rs1, mu_rs2);
        if (!stub_hang) begin
          stub_pending = 1'b1;
          stub_cnt     = stub_lat;
        end
      end
    end
  end

  // Offer one instruction, wait (bounded) for ready, keep valid up one extra cycle, then withdraw.
  task automatic run_op(input string name, input logic [31:0] insn, input logic [31:0] a,
                        input logic [31:0] b, input int busy_cycles,
                        output logic [31:0] rd, output logic wr, output int lat,
                        output logic wait_ok, output int launches);
    int start_launches;
    bit got;
    @(negedge clk);
    start_launches = stub_launches;
    pcpi_valid = 1'b1;
    pcpi_insn  = insn;
    pcpi_rs1   = a;
    pcpi_rs2   = b;
    mu_busy    = 1'b0;
    got = 1'b0; rd = 32'h0; wr = 1'b0; lat = 0; wait_ok = 1'b1;
    for (int c = 1; c <= 200 && !got; c++) begin
      @(negedge clk);
      mu_busy = (c <= busy_cycles);
      if (pcpi_ready) begin
        got = 1'b1; rd = pcpi_rd; wr = pcpi_wr; lat = c;
        if (pcpi_wait) wait_ok = 1'b0;
      end else if (!pcpi_wait) begin
        wait_ok = 1'b0;
      end
    end
    mu_busy = 1'b0;
    check({name, "_ready_seen"}, {31'h0, got}, 32'h1);
    @(negedge clk);
    check({name, "_ready_width"}, {31'h0, pcpi_ready}, 32'h0);
    @(negedge clk);
    check({name, "_no_reissue"}, {31'h0, pcpi_wait}, 32'h0);
    pcpi_valid = 1'b0;
    repeat (2) @(negedge clk);
    launches = stub_launches - start_launches;
    $display("op %s insn=%h rs1=%h rs2=%h -> rd=%h wr=%0d lat=%0d launches=%0d",
             name, insn, a, b, rd, wr, lat, launches);
  endtask

  logic [31:0] rd;
  logic        wr;
  int          lat;
  logic        wait_ok;
  int          launches;
  int          base;
  bit          seen;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; pcpi_valid = 1'b0; pcpi_insn = 32'h0; pcpi_rs1 = 32'h0; pcpi_rs2 = 32'h0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_wait",    {31'h0, pcpi_wait},   32'h0);
    check("rst_ready",   {31'h0, pcpi_ready},  32'h0);
    check("rst_mu_valid",{31'h0, mu_valid},    32'h0);
    check("rst_rd",      pcpi_rd,              32'h0);
    check("rst_op_count",op_count,             32'h0);
    check("rst_timeout", {31'h0, timeout_err}, 32'h0);

    stub_lat = 1;
    run_op("MUL", mk(FUNCT7_M, MUL, OPCODE), 32'h1111FFFF, 32'h1111FFFF, 0, rd, wr, lat, wait_ok, launches);
    check("mul_rd", rd, 32'hDDDC0001);
    check("mul_wr", {31'h0, wr}, 32'h1);
    check("mul_lat", lat, 32'd3);
    check("mul_launches", launches, 32'd1);
    check("mul_op_count", op_count, 32'd1);
    check("mul_mu_insn", mu_instruction, mk(FUNCT7_M, MUL, OPCODE));

    stub_lat = 3;
    run_op("DIV", mk(FUNCT7_M, DIV, OPCODE), 32'h80000000, 32'hFFFFFFFF, 0, rd, wr, lat, wait_ok, launches);
    check("div_rd", rd, 32'h80000000);
    check("div_wait_span", {31'h0, wait_ok}, 32'h1);
    check("div_lat", lat, 32'd5);

    stub_lat = 1;
    run_op("ADDMOD", mk(FUNCT7_M, ADDMOD, OPCODE_CUSTOM), Q - 32'd1, 32'd2, 0, rd, wr, lat, wait_ok, launches);
    check("addmod_rd", rd, 32'd1);
    check("addmod_op_count", op_count, 32'd3);

    // Plain ADD must never be claimed.
    @(negedge clk);
    base = stub_launches;
    pcpi_valid = 1'b1; pcpi_insn = 32'h00B50533; pcpi_rs1 = 32'd1; pcpi_rs2 = 32'd2;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (pcpi_wait || pcpi_ready) seen = 1'b1;
    end
    pcpi_valid = 1'b0;
    check("add_unclaimed", {31'h0, seen}, 32'h0);
    check("add_no_launch", stub_launches - base, 32'd0);
    $display("op ADD insn=00b50533 unclaimed=%0d", !seen);

    run_op("MUL_BUSY", mk(FUNCT7_M, MUL, OPCODE), 32'd7, 32'd6, 5, rd, wr, lat, wait_ok, launches);
    check("busy_rd", rd, 32'd42);
    check("busy_lat", lat, 32'd8);
    check("busy_launches", launches, 32'd1);

    stub_hang = 1'b1;
    run_op("TIMEOUT", mk(FUNCT7_M, MULHU, OPCODE), 32'h12345678, 32'h9ABCDEF0, 0, rd, wr, lat, wait_ok, launches);
    stub_hang = 1'b0;
    check("to_rd", rd, 32'h0);
    check("to_wr", {31'h0, wr}, 32'h0);
    check("to_lat", lat, TO + 2);
    check("to_err", {31'h0, timeout_err}, 32'h1);
    check("to_op_count", op_count, 32'd4);

    // Withdraw during WAIT: the result must be drained and never reported.
    stub_lat = 10;
    @(negedge clk);
    base = stub_launches;
    pcpi_valid = 1'b1; pcpi_insn = mk(FUNCT7_M, DIVU, OPCODE); pcpi_rs1 = 32'd13; pcpi_rs2 = 32'd5;
    repeat (4) @(negedge clk);
    check("flush_in_wait", {31'h0, pcpi_wait}, 32'h1);
    pcpi_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (pcpi_ready) seen = 1'b1;
    end
    check("flush_no_ready", {31'h0, seen}, 32'h0);
    check("flush_launches", stub_launches - base, 32'd1);
    check("flush_op_count", op_count, 32'd4);
    $display("op DIVU_FLUSH insn=%h ready_seen=%0d", mk(FUNCT7_M, DIVU, OPCODE), seen);

    stub_lat = 1;
    run_op("REMU", mk(FUNCT7_M, REMU, OPCODE), 32'd13, 32'd5, 0, rd, wr, lat, wait_ok, launches);
    check("remu_rd", rd, 32'd3);
    check("remu_op_count", op_count, 32'd5);

    // Reset in the middle of WAIT.
    stub_lat = 10;
    @(negedge clk);
    pcpi_valid = 1'b1; pcpi_insn = mk(FUNCT7_M, MUL, OPCODE); pcpi_rs1 = 32'd9; pcpi_rs2 = 32'd9;
    repeat (4) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("mid_rst_wait",     {31'h0, pcpi_wait},   32'h0);
    check("mid_rst_mu_valid", {31'h0, mu_valid},    32'h0);
    check("mid_rst_rd",       pcpi_rd,              32'h0);
    check("mid_rst_op_count", op_count,             32'h0);
    check("mid_rst_timeout",  {31'h0, timeout_err}, 32'h0);
    check("mid_rst_mu_insn",  mu_instruction,       32'h0);
    pcpi_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (pcpi_ready) seen = 1'b1;
    end
    check("mid_rst_no_ready", {31'h0, seen}, 32'h0);

    stub_lat = 2;
    run_op("MULHU", mk(FUNCT7_M, MULHU, OPCODE), 32'hFFFFFFFF, 32'hFFFFFFFF, 0, rd, wr, lat, wait_ok, launches);
    check("mulhu_rd", rd, 32'hFFFFFFFE);
    check("mulhu_lat", lat, 32'd4);
    check("mulhu_op_count", op_count, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_unit_pcpi_issue.md
Name: m_unit_pcpi_issue

Overview:
- Issue/writeback stage between the core's PCPI co-processor port and riscv_m_unit.
- Decodes the offered instruction and claims RV32M and custom modular ops (ADDMOD/SUBMOD/MULQ).
- Launches one operation into riscv_m_unit, holds off the core with pcpi_wait, then returns the registered result as a one-cycle pcpi_ready pulse.
- Handles core flush, a watchdog timeout and re-issue suppression.

Parameters:
- TIMEOUT_CYCLES, 64: max cycles in WAIT before abort; must be ≥ worst-case m-unit latency + 1.
- CNT_W, 32: width of op_count.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- pcpi_valid  in  1  core offers instruction; held with insn/rs1/rs2 stable until pcpi_ready or flush
- pcpi_insn  in  32  offered instruction
- pcpi_rs1  in  32  operand 1
- pcpi_rs2  in  32  operand 2
- pcpi_wr  out  1  write rd back (valid with pcpi_ready)
- pcpi_rd  out  32  result (valid with pcpi_ready)
- pcpi_wait  out  1  claimed, result pending
- pcpi_ready  out  1  one-cycle completion pulse
- mu_valid  out  1  one-cycle launch pulse to riscv_m_unit
- mu_instruction  out  32  latched instruction
- mu_rs1  out  32  latched operand 1
- mu_rs2  out  32  latched operand 2
- mu_wr  in  1  m-unit write flag
- mu_rd  in  32  m-unit result
- mu_busy  in  1  m-unit busy
- mu_ready  in  1  m-unit result pulse
- timeout_err  out  1  sticky; set on watchdog expiry, cleared only by reset
- op_count  out  CNT_W  completed ops; wraps modulo 2^CNT_W

Behaviour:
- Reset: async on resetn low. Clears all outputs, latched operands, state and counters to 0; state = IDLE.
  - A reset in any state aborts immediately.
  - No pcpi_ready is ever produced for an aborted operation.
- Decode (hit):
  - funct7 = 7'b0000001 and opcode = OPCODE (7'h33), any func3; or
  - funct7 = 7'b0000001, opcode = OPCODE_CUSTOM and func3 ∈ {ADDMOD, SUBMOD, MULQ}.
  - Anything else is not claimed: pcpi_wait and pcpi_ready stay 0, so the core traps on its own timeout.
- States: IDLE, ISSUE, WAIT, RESP, HOLD, FLUSH.
- IDLE: on pcpi_valid & hit, latch insn/rs1/rs2 into mu_* and go to ISSUE. pcpi_wait goes high the next cycle.
- ISSUE:
  - pcpi_valid dropped → FLUSH without launching.
  - Otherwise, if mu_busy = 0: mu_valid = 1 for exactly one cycle, then WAIT.
  - If mu_busy = 1: remain in ISSUE.
- WAIT:
  - Watchdog counter increments from 0.
  - mu_ready → capture pcpi_rd = mu_rd, pcpi_wr = mu_wr, go to RESP.
  - pcpi_valid drops before mu_ready → FLUSH.
  - Counter reaches TIMEOUT_CYCLES → pcpi_rd = 0, pcpi_wr = 0, set timeout_err, go to RESP.
  - mu_ready and timeout in the same cycle → mu_ready wins.
- RESP:
  - pcpi_ready = 1 for one cycle and pcpi_wait = 0.
  - op_count increments, but only on a non-timeout completion.
  - Next state HOLD.
- HOLD: one-cycle holdoff, so the core's still-high pcpi_valid is not re-decoded; then IDLE.
- FLUSH: wait for mu_ready if a launch occurred, discard the result, then IDLE. No pcpi_ready.
- pcpi_wait: 1 exactly in ISSUE and WAIT.
- Latency: pcpi_valid sampled at edge N → mu_valid during cycle N+1 (mu_busy low) → mu_ready after L cycles → pcpi_ready one cycle after mu_ready. Total L+2 cycles.
- Outputs pcpi_rd and pcpi_wr hold their values after RESP until the next capture. mu_* operands hold until the next latch.

Decomposition:
- Shared m_definitions package: OPCODE, OPCODE_CUSTOM, func3 enum, Q, plus a new issue_state_t enum and FUNCT7_M constant.
- Sub-module m_issue_decode: combinational hit detection from insn.
- Top contains the FSM, watchdog and counters.

Test Plan:
- MUL: rs1 = 32'h1111FFFF, rs2 = 32'h1111FFFF → exactly one mu_valid pulse, one pcpi_ready with pcpi_rd = 32'hDDDC0001, pcpi_wr = 1; pcpi_valid held 1 extra cycle after ready → no second issue; op_count = 1.
- DIV: rs1 = 32'h80000000, rs2 = 32'hFFFFFFFF → pcpi_rd = 32'h80000000; pcpi_wait high from cycle N+1 until pcpi_ready.
- ADDMOD: rs1 = Q-1, rs2 = 2 → pcpi_rd = 1. Non-M instruction 32'h00B50533 (ADD) → pcpi_wait and pcpi_ready stay 0 for 20 cycles.
- mu_busy held high 5 cycles before launch → mu_valid delayed until busy low; result still correct. Stub m-unit that never asserts mu_ready → pcpi_ready after TIMEOUT_CYCLES with pcpi_rd = 0, pcpi_wr = 0, timeout_err = 1.
- Flush: pcpi_valid dropped during WAIT of DIVU 13/5 → no pcpi_ready; next REMU 13/5 returns 3. resetn pulsed low mid-WAIT → all outputs 0 immediately; a following MULHU FFFFFFFF*FFFFFFFF returns 32'hFFFFFFFE.
